// File: rtl/fifo_rd_packer.sv
// Read-side packer: drains a show-ahead fifo and packs PACK words into one valid/ready beat.
// Optional partial-beat timeout flush is built when FIFO_RD_TMO_EN is defined.
module fifo_rd_packer #(
    parameter int WIDTH      = 4,
    parameter int PACK       = 4,
    parameter int TMO_CYCLES = 16
) (
    input  logic                  rclk,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0]      fifo_dat,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic [WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PACK - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [WIDTH*PACK-1:0] data_reg, data_next;
    logic [PACK-1:0]       keep_reg, keep_next;
    logic                  valid_reg, valid_next;

`ifdef FIFO_RD_TMO_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    logic [TW-1:0]         tmr_reg, tmr_next;
    logic [WIDTH*PACK-1:0] keep_wide;

    // Word-granular mask so a flushed partial beat carries zeros in unfilled slots.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_keep_wide
        assign keep_wide[gi*WIDTH +: WIDTH] = {WIDTH{keep_reg[gi]}};
    end
`endif

    // Gated by rst_ni so no word is popped (and lost) while held in reset.
    assign fifo_ren = rst_ni & (state_reg == FILL) & ~fifo_empty;
    assign m_data   = data_reg;
    assign m_keep   = keep_reg;
    assign m_valid  = valid_reg;
    assign busy     = (state_reg == HOLD) | (cnt_reg != '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        keep_next  = keep_reg;
        valid_next = valid_reg;
`ifdef FIFO_RD_TMO_EN
        tmr_next   = tmr_reg;
`endif
        case (state_reg)
            FILL: begin
                if (fifo_ren) begin
                    data_next[cnt_reg*WIDTH +: WIDTH] = fifo_dat;
                    keep_next[cnt_reg]                = 1'b1;
`ifdef FIFO_RD_TMO_EN
                    tmr_next = '0;
`endif
                    if (cnt_reg == LAST_SLOT) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef FIFO_RD_TMO_EN
                else if (cnt_reg != '0) begin
                    if (tmr_reg == TMO_LAST) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        valid_next = 1'b1;
                        data_next  = data_reg & keep_wide;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
`endif
            end
            HOLD: begin
                if (m_ready) begin
                    state_next = FILL;
                    valid_next = 1'b0;
                    keep_next  = '0;
`ifdef FIFO_RD_TMO_EN
                    tmr_next   = '0;
`endif
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            data_reg  <= '0;
            keep_reg  <= '0;
            valid_reg <= 1'b0;
`ifdef FIFO_RD_TMO_EN
            tmr_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            keep_reg  <= keep_next;
            valid_reg <= valid_next;
`ifdef FIFO_RD_TMO_EN
            tmr_reg   <= tmr_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (WIDTH=4, PACK=4, TMO_CYCLES=16) with a small show-ahead fifo model.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  fifo_dat;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;

    logic [3:0]  mem [0:255];
    int          wcnt = 0;
    int          rptr = 0;
    int          rd_count = 0;
    int          viol = 0;
    logic        force_empty = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          rd0;

    fifo_rd_packer #(.WIDTH(4), .PACK(4), .TMO_CYCLES(16)) dut (
        .rclk       (rclk),
        .rst_ni     (rst_ni),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    always #5 rclk = ~rclk;

    assign fifo_empty = force_empty | (rptr == wcnt);
    assign fifo_dat   = mem[rptr[7:0]];

    always @(posedge rclk) begin
        if (fifo_ren) begin
            rptr     <= rptr + 1;
            rd_count <= rd_count + 1;
        end
        if (fifo_ren && fifo_empty) viol <= viol + 1;
    end

    task automatic tick();
        @(negedge rclk);
        #1;
    endtask

    task automatic push(input logic [3:0] w);
        mem[wcnt[7:0]] = w;
        wcnt = wcnt + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [10:0] exp_ren;
        logic [10:0] exp_val;
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;

        // Reset state, with m_ready already high (test 6 setup)
        m_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_keep",  32'(m_keep),  32'd0);
        check("rst_data",  32'(m_data),  32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_ren",   32'(fifo_ren), 32'd0);
        rst_ni = 1'b1;

        // Test 6: m_ready high, fifo empty -> nothing happens
        for (int k = 0; k < 50; k++) begin
            tick();
            check("idle_ready", 32'({m_valid, fifo_ren, busy}), 32'd0);
        end

        // Test 1: streaming with m_ready=1, 8 words -> two beats, one-cycle read gap
        exp_ren = 11'b00111101111;
        exp_val = 11'b01000010000;
        for (int i = 1; i <= 8; i++) push(4'(i));
        force_empty = 1'b0;
        #1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick();
            check($sformatf("t1_ren_k%0d", k), 32'(fifo_ren), 32'(exp_ren[k]));
            check($sformatf("t1_val_k%0d", k), 32'(m_valid),  32'(exp_val[k]));
            if (k == 4) begin
                check("t1_data0", 32'(m_data), 32'h4321);
                check("t1_keep0", 32'(m_keep), 32'hF);
            end
            if (k == 9) check("t1_data1", 32'(m_data), 32'h8765);
        end

        // Test 2: backpressure for 10 cycles, then release
        m_ready = 1'b0;
        rd0 = rd_count;
        push(4'hA); push(4'hB); push(4'hC); push(4'hD);
        push(4'hE); push(4'hF); push(4'h1); push(4'h2);
        #1;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) tick();
            if (k == 4 || k == 9) begin
                check($sformatf("t2_val_k%0d", k),  32'(m_valid),  32'd1);
                check($sformatf("t2_data_k%0d", k), 32'(m_data),   32'hDCBA);
                check($sformatf("t2_keep_k%0d", k), 32'(m_keep),   32'hF);
                check($sformatf("t2_ren_k%0d", k),  32'(fifo_ren), 32'd0);
            end
            if (k == 9) m_ready = 1'b1;
            if (k == 14) begin
                check("t2_val2",  32'(m_valid), 32'd1);
                check("t2_data2", 32'(m_data),  32'h21FE);
                check("t2_keep2", 32'(m_keep),  32'hF);
                check("t2_reads", 32'(rd_count - rd0), 32'd8);
            end
        end
        tick();
        m_ready = 1'b0;

        // Test 4: empty toggling every cycle across 4 words
        rd0 = rd_count;
        push(4'h9); push(4'hA); push(4'hB); push(4'hC);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            force_empty = ((k % 2) != 0);
            #1;
            if (k == 7) begin
                check("t4_val",   32'(m_valid), 32'd1);
                check("t4_data",  32'(m_data),  32'hCBA9);
                check("t4_keep",  32'(m_keep),  32'hF);
                check("t4_reads", 32'(rd_count - rd0), 32'd4);
            end
        end
        force_empty = 1'b0;
        check("t4_ren_on_empty", 32'(viol), 32'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Test 5a: async reset with cnt=2
        push(4'h3); push(4'h4);
        tick(); tick();
        check("t5_busy_cnt2", 32'(busy), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("t5a_valid", 32'(m_valid), 32'd0);
        check("t5a_keep",  32'(m_keep),  32'd0);
        check("t5a_data",  32'(m_data),  32'd0);
        check("t5a_busy",  32'(busy),    32'd0);
        push(4'h5); push(4'h6); push(4'h7); push(4'h8);
        #0;
        check("t5a_ren_in_rst", 32'(fifo_ren), 32'd0);
        rst_ni = 1'b1;
        tick(); tick(); tick(); tick();
        check("t5_fresh_val",  32'(m_valid), 32'd1);
        check("t5_fresh_data", 32'(m_data),  32'h8765);
        check("t5_fresh_keep", 32'(m_keep),  32'hF);

        // Test 5b: async reset while in HOLD
        #1 rst_ni = 1'b0;
        #1;
        check("t5b_valid", 32'(m_valid), 32'd0);
        check("t5b_keep",  32'(m_keep),  32'd0);
        check("t5b_data",  32'(m_data),  32'd0);
        check("t5b_busy",  32'(busy),    32'd0);
        #1 rst_ni = 1'b1;
        tick();

        // Test 3: two words then a long idle gap
        push(4'h5); push(4'h6);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            if (k == 17) begin
                check("t3_val_k17",  32'(m_valid), 32'd0);
                check("t3_busy_k17", 32'(busy),    32'd1);
            end
`ifdef FIFO_RD_TMO_EN
            if (k == 18) begin
                check("t3_val_flush",  32'(m_valid), 32'd1);
                check("t3_data_flush", 32'(m_data),  32'h0065);
                check("t3_keep_flush", 32'(m_keep),  32'h3);
            end
`else
            if (k == 19) begin
                check("t3_val_nt",  32'(m_valid), 32'd0);
                check("t3_busy_nt", 32'(busy),    32'd1);
            end
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
